// File: rtl/threshold_sweep_ctrl.sv
// Threshold sweep controller: drives a one-hot ladder tap, majority-votes a
// synchronised comparator and runs single, linear-sweep or SAR conversions.
module threshold_sweep_ctrl #(
   parameter int N_SEL      = 3,
   parameter int SETTLE_CYC = 4,
   parameter int N_SAMP     = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [1:0]          mode,
   input  logic [N_SEL-1:0]    tap_sel,
   input  logic                cmp_in,
   output logic [2**N_SEL-1:0] y_d,
   output logic [2**N_SEL-1:0] n_d,
   output logic                busy,
   output logic                done,
   output logic [N_SEL-1:0]    result,
   output logic                under,
   output logic                over,
   output logic [2:0]          o_dbg_state
);
   localparam int TAPS = 2**N_SEL;
   localparam int CMAX = (SETTLE_CYC > N_SAMP) ? SETTLE_CYC : N_SAMP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int OW   = $clog2(N_SAMP + 1);
   localparam logic [N_SEL-1:0] CODE_MAX    = {N_SEL{1'b1}};
   localparam logic [N_SEL-1:0] CODE_MID    = N_SEL'(TAPS / 2);
   localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0]    SAMP_LAST   = CW'(N_SAMP - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_SAMPLE = 3'd2,
      S_DECIDE = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state;
   logic [1:0]       r_sync;
   logic [1:0]       r_mode;
   logic [N_SEL-1:0] r_code;
   logic [N_SEL-1:0] r_next_code;
   logic [N_SEL-1:0] r_acc;
   logic [N_SEL-1:0] r_bit;
   logic [CW-1:0]    r_cnt;
   logic [OW-1:0]    r_ones;
   logic [TAPS-1:0]  r_y_d;
   logic [TAPS-1:0]  r_n_d;
   logic             r_busy;
   logic             r_done;
   logic [N_SEL-1:0] r_result;
   logic             r_under;
   logic             r_over;

   logic [OW-1:0]    w_ones_tot;
   logic [OW:0]      w_twice;
   logic             w_decision;
   logic             w_final;
   logic [N_SEL-1:0] w_res;
   logic [N_SEL-1:0] w_next;
   logic [N_SEL-1:0] w_acc_new;
   logic [N_SEL-1:0] w_init_code;
   logic             w_under;
   logic             w_over;

   function automatic logic [TAPS-1:0] onehot(input logic [N_SEL-1:0] c);
      onehot    = '0;
      onehot[c] = 1'b1;
   endfunction

   // The decision includes the sample taken on the closing SAMPLE edge, so a
   // terminal outcome goes straight to DONE and the last tap costs no extra cycle.
   always_comb begin
      w_ones_tot  = r_ones + OW'(r_sync[1]);
      w_twice     = {w_ones_tot, 1'b0};
      w_decision  = w_twice > (OW+1)'(N_SAMP);
      w_acc_new   = w_decision ? r_code : r_acc;
      w_final     = 1'b1;
      w_next      = r_code;
      w_res       = r_code;
      w_under     = ~w_decision;
      w_over      = w_decision & (r_code == CODE_MAX);
      case (r_mode)
         2'b01: begin
            w_final = ~w_decision | (r_code == CODE_MAX);
            w_next  = r_code + N_SEL'(1);
            if (w_decision) begin
               w_res   = CODE_MAX;
               w_under = 1'b0;
               w_over  = 1'b1;
            end else begin
               w_res   = (r_code == '0) ? '0 : r_code - N_SEL'(1);
               w_under = (r_code == '0);
               w_over  = 1'b0;
            end
         end
         2'b10: begin
            w_final = r_bit[0];
            w_next  = w_acc_new | (r_bit >> 1);
            w_res   = w_acc_new;
            w_under = (w_acc_new == '0);
            w_over  = (w_acc_new == CODE_MAX);
         end
         default: ;
      endcase
      case (mode)
         2'b01:   w_init_code = '0;
         2'b10:   w_init_code = CODE_MID;
         default: w_init_code = tap_sel;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sync      <= '0;
         r_mode      <= '0;
         r_code      <= '0;
         r_next_code <= '0;
         r_acc       <= '0;
         r_bit       <= '0;
         r_cnt       <= '0;
         r_ones      <= '0;
         r_y_d       <= '0;
         r_n_d       <= '1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= '0;
         r_under     <= 1'b0;
         r_over      <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], cmp_in};
         r_done <= 1'b0;
         if (abort && (r_state != S_IDLE)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_y_d   <= '0;
            r_n_d   <= '1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start) begin
                     r_state <= S_SETTLE;
                     r_busy  <= 1'b1;
                     r_mode  <= mode;
                     r_under <= 1'b0;
                     r_over  <= 1'b0;
                     r_cnt   <= '0;
                     r_acc   <= '0;
                     r_bit   <= CODE_MID;
                     r_code  <= w_init_code;
                     r_y_d   <= onehot(w_init_code);
                     r_n_d   <= ~onehot(w_init_code);
                  end
               end
               S_SETTLE: begin
                  if (r_cnt == SETTLE_LAST) begin
                     r_state <= S_SAMPLE;
                     r_cnt   <= '0;
                     r_ones  <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               S_SAMPLE: begin
                  r_ones <= w_ones_tot;
                  if (r_cnt == SAMP_LAST) begin
                     if (w_final) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_res;
                        r_under  <= w_under;
                        r_over   <= w_over;
                     end else begin
                        r_state     <= S_DECIDE;
                        r_next_code <= w_next;
                        r_acc       <= w_acc_new;
                        r_bit       <= r_bit >> 1;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               S_DECIDE: begin
                  r_state <= S_SETTLE;
                  r_cnt   <= '0;
                  r_code  <= r_next_code;
                  r_y_d   <= onehot(r_next_code);
                  r_n_d   <= ~onehot(r_next_code);
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_y_d   <= '0;
                  r_n_d   <= '1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign y_d         = r_y_d;
   assign n_d         = r_n_d;
   assign busy        = r_busy;
   assign done        = r_done;
   assign result      = r_result;
   assign under       = r_under;
   assign over        = r_over;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_threshold_sweep_ctrl.sv
// Directed bench for threshold_sweep_ctrl: an abstract conversion model yields
// the tested-tap list and final code; a negedge process compares every cycle.
module tb_threshold_sweep_ctrl;
   localparam int TAPS    = 8;
   localparam int PER_TAP = 8;

   logic       clk = 1'b0;
   logic       rst, start, abort, cmp_in;
   logic [1:0] mode;
   logic [2:0] tap_sel;
   logic [7:0] y_d, n_d;
   logic       busy, done, under, over;
   logic [2:0] result;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   threshold_sweep_ctrl #(.N_SEL(3), .SETTLE_CYC(4), .N_SAMP(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .tap_sel(tap_sel), .cmp_in(cmp_in), .y_d(y_d), .n_d(n_d), .busy(busy),
      .done(done), .result(result), .under(under), .over(over),
      .o_dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic       chk_en = 1'b0;
   logic [7:0] exp_y, exp_n;
   logic       exp_busy, exp_done, exp_under, exp_over;
   logic [2:0] exp_result;
   int         cyc_in_conv;
   int         done_seen_cyc;

   int m_taps[$];
   int m_result;
   bit m_under, m_over;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc_in_conv, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("y_d", y_d, exp_y);
         check("n_d", n_d, exp_n);
         check("busy", busy, exp_busy);
         check("done", done, exp_done);
         check("result", result, exp_result);
         check("under", under, exp_under);
         check("over", over, exp_over);
         if (done === 1'b1) done_seen_cyc = cyc_in_conv;
      end
   end

   // Comparator answers 1 for every tap at or below thr.
   task automatic model_conv(input logic [1:0] md, input int tsel, input int thr);
      int acc;
      m_taps.delete();
      m_under = 0;
      m_over  = 0;
      acc     = 0;
      if (md == 2'b01) begin
         for (int t = 0; t < TAPS; t++) begin
            m_taps.push_back(t);
            if (!(t <= thr)) begin
               m_result = (t == 0) ? 0 : t - 1;
               m_under  = (t == 0);
               break;
            end
            if (t == TAPS - 1) begin
               m_result = t;
               m_over   = 1;
            end
         end
      end else if (md == 2'b10) begin
         for (int b = TAPS / 2; b >= 1; b = b / 2) begin
            m_taps.push_back(acc | b);
            if ((acc | b) <= thr) acc = acc | b;
         end
         m_result = acc;
         m_under  = (acc == 0);
         m_over   = (acc == TAPS - 1);
      end else begin
         m_taps.push_back(tsel);
         m_result = tsel;
         m_under  = !(tsel <= thr);
         m_over   = (tsel <= thr) && (tsel == TAPS - 1);
      end
   endtask

   // stop_kind: 0 none, 1 abort in stop_cyc, 2 reset pulse from stop_cyc on.
   // flip inverts the driven comparator in the cycles whose bit is set.
   task automatic run_conv(input logic [1:0] md, input int tsel, input int thr_drv,
                           input int thr_mdl, input int flip, input int stop_kind,
                           input int stop_cyc, input int again_cyc, input int exp_done_cyc);
      int total, last, tap;
      bit idle;
      model_conv(md, tsel, thr_mdl);
      total   = PER_TAP * m_taps.size();
      last    = (stop_kind != 0) ? stop_cyc + 2 : total + 1;
      mode    = md;
      tap_sel = 3'(tsel);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      mode    = 2'($urandom_range(0, 3));
      tap_sel = 3'($urandom_range(0, 7));
      done_seen_cyc = 0;
      exp_under = 1'b0;
      exp_over  = 1'b0;
      for (int c = 1; c <= last; c++) begin
         cyc_in_conv = c;
         start = (c == again_cyc);
         abort = (stop_kind == 1) && (c == stop_cyc);
         if (stop_kind == 2 && c == stop_cyc) begin
            rst        = 1'b1;
            exp_result = '0;
            exp_under  = 1'b0;
            exp_over   = 1'b0;
         end
         idle = (c > total) || (stop_kind == 1 && c > stop_cyc) || (stop_kind == 2 && c >= stop_cyc);
         exp_y = '0;
         if (idle) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            cmp_in   = 1'b0;
         end else begin
            tap        = m_taps[(c - 1) / PER_TAP];
            exp_y[tap] = 1'b1;
            exp_busy   = 1'b1;
            exp_done   = (c == total);
            cmp_in     = (tap <= thr_drv) ^ flip[c];
            if (c == total) begin
               exp_result = 3'(m_result);
               exp_under  = m_under;
               exp_over   = m_over;
            end
         end
         exp_n = ~exp_y;
         @(posedge clk); #1;
      end
      start  = 1'b0;
      abort  = 1'b0;
      cmp_in = 1'b0;
      check("done_cycle", done_seen_cyc, exp_done_cyc);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; tap_sel = '0; cmp_in = 1'b0;
      exp_y = '0; exp_n = '1; exp_busy = 1'b0; exp_done = 1'b0;
      exp_result = '0; exp_under = 1'b0; exp_over = 1'b0; cyc_in_conv = 0; done_seen_cyc = 0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single tap 5, comparator high; extra start mid-conversion is ignored
      run_conv(2'b00, 5, 7, 7, 0, 0, 0, 3, 8);
      check("single5_result", result, 5);
      check("single5_under", under, 0);
      check("single5_over", over, 0);

      // linear sweep with comparator high up to tap 3
      run_conv(2'b01, 0, 3, 3, 0, 0, 0, 20, 40);
      check("lin3_ntaps", m_taps.size(), 5);
      check("lin3_result", result, 3);
      check("lin3_flags", {under, over}, 0);

      // binary search, same comparator
      run_conv(2'b10, 0, 3, 3, 0, 0, 0, 0, 24);
      check("bin3_trial0", m_taps[0], 4);
      check("bin3_trial1", m_taps[1], 2);
      check("bin3_trial2", m_taps[2], 3);
      check("bin3_result", result, 3);

      // linear extremes
      run_conv(2'b01, 0, 7, 7, 0, 0, 0, 0, 64);
      check("lin_all1_result", result, 7);
      check("lin_all1_over", over, 1);
      run_conv(2'b01, 0, -1, -1, 0, 0, 0, 0, 8);
      check("lin_all0_result", result, 0);
      check("lin_all0_under", under, 1);

      // single top tap sets over; start in the DONE cycle is ignored
      run_conv(2'b00, 7, 7, 7, 0, 0, 0, 8, 8);
      check("single7_over", over, 1);
      // reserved mode behaves as single
      run_conv(2'b11, 2, 1, 1, 0, 0, 0, 0, 8);
      check("mode3_result", result, 2);
      check("mode3_under", under, 1);

      // majority vote: one low sample keeps decision 1, two low samples flip it
      run_conv(2'b00, 5, 7, 7, 32'h10, 0, 0, 0, 8);
      check("glitch1_under", under, 0);
      run_conv(2'b00, 5, 7, -1, 32'h30, 0, 0, 0, 8);
      check("glitch2_under", under, 1);
      // early-settle comparator activity is ignored
      run_conv(2'b00, 3, -1, -1, 32'h6, 0, 0, 0, 8);
      check("settle_glitch_under", under, 1);

      // more SAR codes
      run_conv(2'b10, 0, 0, 0, 0, 0, 0, 0, 24);
      check("bin0_under", under, 1);
      run_conv(2'b10, 0, 7, 7, 0, 0, 0, 0, 24);
      check("bin7_over", over, 1);
      run_conv(2'b10, 0, 5, 5, 0, 0, 0, 0, 24);
      check("bin5_trial1", m_taps[1], 6);
      check("bin5_result", result, 5);

      // abort in cycle 10 keeps the previous result, no done
      run_conv(2'b01, 0, 3, 3, 0, 1, 10, 0, 0);
      check("abort_result_kept", result, 5);

      // reset mid-sweep, then a start together with reset release
      run_conv(2'b01, 0, 3, 3, 0, 2, 12, 0, 0);
      check("rst_result", result, 0);
      rst = 1'b0;
      run_conv(2'b00, 6, 7, 7, 0, 0, 0, 0, 8);
      check("post_rst_result", result, 6);

      repeat (2) @(posedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
